inst_fetch_queue: RTL and testbench

Instruction queue directly downstream of the instruction cache fetch stage. Accepts one fetch packet per cycle (up to FETCH_SIZE instructions with a per-slot valid mask, fetch exception and attached BPU info), compacts the valid slots into a circular per-instruction buffer, and presents up to ISSUE_WIDTH in-order instructions per cycle to the decoder. Its `ready_o` drives the fetch stage's queue-ready input and is the sole back-pressure source into fetch.

---
 rtl/inst_fetch_queue.sv | 125 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction queue between the icache fetch stage and decode. Each cycle it
//   accepts one fetch packet of up to FETCH_SIZE slots and compacts the valid
//   slots into a circular buffer, one entry per instruction. Up to ISSUE_WIDTH
//   in-order instructions are offered to decode per cycle.
//
// Ports
//   clk, rst_n   clock; synchronous active-low reset
//   clr_i        flush: drops all buffered entries and any same-cycle push/pop
//   vpc_i        packet virtual PC; the packet base is aligned to FETCH_SIZE*4
//   valid_i      per-slot valid mask; slots need not be contiguous
//   inst_i       slot k at [32k+31:32k]
//   excp_i       packet exception {ppi, pif, tlbr, adef}
//   attached_i   packet BPU info, copied into every pushed entry
//   ready_o      a whole packet fits; the only back-pressure into fetch
//   valid_o      per-lane valid, always contiguous from lane 0
//   pc_o, inst_o, excp_o, attached_o   per-lane payload
//   ready_i      decode takes every lane whose valid_o is set
module inst_fetch_queue #(
    parameter int FETCH_SIZE          = 2,
    parameter int ISSUE_WIDTH         = 2,
    parameter int DEPTH               = 8,
    parameter int ATTACHED_INFO_WIDTH = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       clr_i,
    input  logic [31:0]                                vpc_i,
    input  logic [FETCH_SIZE-1:0]                      valid_i,
    input  logic [FETCH_SIZE*32-1:0]                   inst_i,
    input  logic [3:0]                                 excp_i,
    input  logic [ATTACHED_INFO_WIDTH-1:0]             attached_i,
    output logic                                       ready_o,
    output logic [ISSUE_WIDTH-1:0]                     valid_o,
    output logic [ISSUE_WIDTH*32-1:0]                  pc_o,
    output logic [ISSUE_WIDTH*32-1:0]                  inst_o,
    output logic [ISSUE_WIDTH*4-1:0]                   excp_o,
    output logic [ISSUE_WIDTH*ATTACHED_INFO_WIDTH-1:0] attached_o,
    input  logic                                       ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] ALIGN_MASK = ~(32'(FETCH_SIZE * 4) - 32'd1);

    typedef struct packed {
        logic [31:0]                    pc;
        logic [31:0]                    inst;
        logic [3:0]                     excp;
        logic [ATTACHED_INFO_WIDTH-1:0] att;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic [CW-1:0]   slot_off [FETCH_SIZE];
    logic [FETCH_SIZE-1:0] slot_we;
    entry_t          wdata [FETCH_SIZE];
    logic [CW-1:0]   push_cnt, push_n, pop_n, avail;
    logic            has_excp, push;
    logic [31:0]     pc_base;

    assign has_excp = |excp_i;
    assign push     = ready_o & (|valid_i);
    assign pc_base  = vpc_i & ALIGN_MASK;

    // Free space is judged from the registered count only, so a pop in the
    // same cycle never frees credit and ready_i has no path to ready_o.
    assign ready_o = (count <= CW'(DEPTH - FETCH_SIZE));

    // Slot k lands at wr_ptr + (number of valid slots below k). An exception
    // packet keeps only its lowest valid slot, which is the one at offset 0.
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int k = 0; k < FETCH_SIZE; k++) begin
            slot_off[k] = acc;
            acc         = acc + CW'(valid_i[k]);
            slot_we[k]  = push & valid_i[k] & (~has_excp | (slot_off[k] == '0));
            wdata[k].pc   = pc_base + 32'(k * 4);
            wdata[k].inst = has_excp ? 32'd0 : inst_i[32*k +: 32];
            wdata[k].excp = excp_i;
            wdata[k].att  = attached_i;
        end
        push_cnt = acc;
    end

    assign push_n = !push ? '0 : (has_excp ? CW'(1) : push_cnt);
    assign avail  = (count > CW'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH) : count;
    assign pop_n  = ready_i ? avail : '0;

    // Entry storage is deliberately not reset; pointers and count gate it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_SIZE; k++) begin
            if (slot_we[k] && !clr_i)
                mem[wr_ptr + slot_off[k][PW-1:0]] <= wdata[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + push_n - pop_n;
            wr_ptr <= wr_ptr + push_n[PW-1:0];
            rd_ptr <= rd_ptr + pop_n[PW-1:0];
        end
    end

    // Output lanes: combinational reads of registered storage; index wraps
    // naturally in PW bits.
    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_lane
        logic [PW-1:0] idx;
        assign idx        = rd_ptr + PW'(j);
        assign valid_o[j] = (count > CW'(j));
        assign pc_o[32*j +: 32]     = mem[idx].pc;
        assign inst_o[32*j +: 32]   = mem[idx].inst;
        assign excp_o[4*j +: 4]     = mem[idx].excp;
        assign attached_o[ATTACHED_INFO_WIDTH*j +: ATTACHED_INFO_WIDTH] = mem[idx].att;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int FS  = 2;
    localparam int IW  = 2;
    localparam int DP  = 8;
    localparam int AW  = 32;

    logic            clk = 1'b0;
    logic            rst_n, clr_i, ready_i;
    logic [31:0]     vpc_i;
    logic [FS-1:0]   valid_i;
    logic [FS*32-1:0] inst_i;
    logic [3:0]      excp_i;
    logic [AW-1:0]   attached_i;
    logic            ready_o;
    logic [IW-1:0]   valid_o;
    logic [IW*32-1:0] pc_o, inst_o;
    logic [IW*4-1:0] excp_o;
    logic [IW*AW-1:0] attached_o;

    inst_fetch_queue #(.FETCH_SIZE(FS), .ISSUE_WIDTH(IW), .DEPTH(DP),
                       .ATTACHED_INFO_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .vpc_i(vpc_i),
        .valid_i(valid_i), .inst_i(inst_i), .excp_i(excp_i),
        .attached_i(attached_i), .ready_o(ready_o), .valid_o(valid_o),
        .pc_o(pc_o), .inst_o(inst_o), .excp_o(excp_o),
        .attached_o(attached_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  excp;
        logic [31:0] att;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every lane decode takes at the coming edge is popped from the
    // scoreboard and compared. Flush/reset cycles consume nothing.
    always @(negedge clk) begin
        if (rst_n && !clr_i && ready_i) begin
            for (int j = 0; j < IW; j++) begin
                if (valid_o[j]) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL lane%0d_unexpected: got pc %h, expected no entry", j, pc_o[32*j +: 32]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (pc_o[32*j +: 32] !== e.pc || inst_o[32*j +: 32] !== e.inst ||
                            excp_o[4*j +: 4] !== e.excp || attached_o[AW*j +: AW] !== e.att) begin
                            miscompares++;
                            $display("FAIL lane%0d_entry: got pc %h inst %h excp %h att %h, expected pc %h inst %h excp %h att %h",
                                     j, pc_o[32*j +: 32], inst_o[32*j +: 32], excp_o[4*j +: 4],
                                     attached_o[AW*j +: AW], e.pc, e.inst, e.excp, e.att);
                        end
                    end
                end
            end
        end
    end

    // Drive one packet (waiting, bounded, for ready_o) and record what decode
    // must eventually see.
    task automatic send(input logic [31:0] vpc, input logic [1:0] vm, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [3:0] ex, input logic [31:0] att);
        int w;
        logic [31:0] base;
        logic [31:0] ins [2];
        exp_t e;
        w = 0;
        while (!ready_o && w < 20) begin
            ready_i = 1'b1;
            step();
            w++;
        end
        if (!ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL send_wait: got ready_o 0 after %0d cycles, expected 1", w);
            return;
        end
        vpc_i = vpc; valid_i = vm; inst_i = {i1, i0}; excp_i = ex; attached_i = att;
        base = {vpc[31:3], 3'b000};
        ins[0] = i0; ins[1] = i1;
        if (ex != 4'd0) begin
            e.pc = vm[0] ? base : base + 32'd4;
            e.inst = 32'd0; e.excp = ex; e.att = att;
            sb.push_back(e);
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (vm[k]) begin
                    e.pc = base + 32'(k * 4); e.inst = ins[k]; e.excp = 4'd0; e.att = att;
                    sb.push_back(e);
                end
            end
        end
        step();
        valid_i = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        ready_i = 1'b1;
        while (valid_o != '0 && w < 20) begin
            step();
            w++;
        end
        ready_i = 1'b0;
        check("drain_empty", 32'(valid_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] masks [4];
        masks[0] = 2'b11; masks[1] = 2'b01; masks[2] = 2'b10; masks[3] = 2'b11;
        rst_n = 1'b0; clr_i = 1'b0; ready_i = 1'b0; vpc_i = '0; valid_i = '0;
        inst_i = '0; excp_i = '0; attached_i = '0;
        step(); step();
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        rst_n = 1'b1;

        // First packet: full mask
        send(32'h1c00_0000, 2'b11, 32'hA000_0000, 32'hA000_0001, 4'd0, 32'h0000_00B0);
        check("first_valid_o", 32'(valid_o), 32'd3);
        check("first_pc0", pc_o[31:0], 32'h1c00_0000);
        check("first_pc1", pc_o[63:32], 32'h1c00_0004);
        check("first_inst1", inst_o[63:32], 32'hA000_0001);
        drain();

        // Partial mask: only slot 1
        send(32'h1c00_0008, 2'b10, 32'hA000_0010, 32'hA000_0011, 4'd0, 32'h0000_00B1);
        check("partial_valid_o", 32'(valid_o), 32'd1);
        check("partial_pc0", pc_o[31:0], 32'h1c00_000c);
        drain();

        // Exception packets: lowest valid slot only, inst zeroed
        send(32'h1c00_0010, 2'b11, 32'hA000_0020, 32'hA000_0021, 4'b0010, 32'h0000_00B2);
        check("excp_valid_o", 32'(valid_o), 32'd1);
        check("excp_inst0", inst_o[31:0], 32'd0);
        check("excp_excp0", 32'(excp_o[3:0]), 32'h2);
        drain();
        send(32'h1c00_0018, 2'b10, 32'hA000_0030, 32'hA000_0031, 4'b1000, 32'h0000_00B3);
        check("excp_hi_pc0", pc_o[31:0], 32'h1c00_001c);
        drain();

        // Fill to DEPTH with decode stalled
        ready_i = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check("full_ready_before", 32'(ready_o), 32'd1);
            send(32'h1c00_0100 + 32'(p * 8), 2'b11, 32'hB000_0000 + 32'(2 * p),
                 32'hB000_0001 + 32'(2 * p), 4'd0, 32'(p));
        end
        check("full_ready_o", 32'(ready_o), 32'd0);
        check("full_valid_o", 32'(valid_o), 32'd3);
        ready_i = 1'b1;
        #1;
        check("full_ready_in_pop_cycle", 32'(ready_o), 32'd0);
        step();
        ready_i = 1'b0;
        check("full_ready_after_pop", 32'(ready_o), 32'd1);
        drain();

        // Sequential stream with random decode stalls, crossing pointer wrap
        for (int p = 0; p < 20; p++) begin
            ready_i = 1'($urandom_range(0, 1));
            send(32'h1c00_1000 + 32'(p * 8), masks[p % 4], 32'hC000_0000 + 32'(2 * p),
                 32'hC000_0001 + 32'(2 * p), 4'd0, 32'h100 + 32'(p));
        end
        drain();

        // Flush racing a push and a pop at count 5
        ready_i = 1'b0;
        send(32'h1c00_2000, 2'b11, 32'hD000_0000, 32'hD000_0001, 4'd0, 32'h200);
        send(32'h1c00_2008, 2'b11, 32'hD000_0002, 32'hD000_0003, 4'd0, 32'h201);
        send(32'h1c00_2010, 2'b01, 32'hD000_0004, 32'hD000_0005, 4'd0, 32'h202);
        vpc_i = 32'h1c00_2018; valid_i = 2'b11; inst_i = {32'hDEAD_0001, 32'hDEAD_0000};
        excp_i = '0; ready_i = 1'b1; clr_i = 1'b1;
        sb.delete();
        step();
        clr_i = 1'b0; valid_i = '0; ready_i = 1'b0;
        check("flush_valid_o", 32'(valid_o), 32'd0);
        check("flush_ready_o", 32'(ready_o), 32'd1);
        send(32'h1c00_3000, 2'b11, 32'hE000_0000, 32'hE000_0001, 4'd0, 32'h300);
        check("post_flush_pc0", pc_o[31:0], 32'h1c00_3000);
        drain();

        // Reset mid-operation behaves like a flush
        send(32'h1c00_4000, 2'b11, 32'hF000_0000, 32'hF000_0001, 4'd0, 32'h400);
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        check("midreset_valid_o", 32'(valid_o), 32'd0);
        check("midreset_ready_o", 32'(ready_o), 32'd1);
        send(32'h1c00_5008, 2'b01, 32'hF000_0010, 32'hF000_0011, 4'd0, 32'h500);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
